// File: rtl/q115_act_stage_if.sv
// rtl/q115_act_stage_if.sv - accumulator-in / activated-result-out handshake bundle
// slave is the activation stage side, master is the producer/consumer side.
interface q115_act_stage_if #(
  parameter int DATA_BITS = 16
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;
  logic [DATA_BITS-1:0] bias;
  logic [1:0]           act_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;

  modport slave (
    input  in_valid, in_data, bias, act_mode, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, bias, act_mode, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/q115_act_stage.sv
// rtl/q115_act_stage.sv - Q1.15 bias-add + activation pipeline with FWFT output FIFO
// Optional leaky-ReLU path compiled in by macro LEAKY_RELU_EN.
module q115_act_stage #(
  parameter int DATA_BITS  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  q115_act_stage_if.slave       bus,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            sat_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [DATA_BITS-1:0] MAX_POS = {1'b0, {(DATA_BITS-1){1'b1}}};
  localparam logic [DATA_BITS-1:0] MIN_NEG = {1'b1, {(DATA_BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_next;

  logic                 s1_valid, s2_valid;
  logic [DATA_BITS-1:0] s1_data, s2_data;
  logic [1:0]           s1_mode;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        fifo_count;
  logic [CW:0]          occupancy;
  logic                 accept, push, pop, all_empty;
  logic [DATA_BITS:0]   sum;
  logic                 sum_sat;
  logic [DATA_BITS-1:0] sum_q, act_data;

  assign accept    = bus.in_valid && bus.in_ready;
  assign push      = enable && s2_valid;
  assign pop       = bus.out_valid && bus.out_ready;
  assign all_empty = !s1_valid && !s2_valid && (fifo_count == '0);
  // Admission counts in-flight stages so a beat always has a FIFO slot waiting.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(s1_valid) + (CW+1)'(s2_valid);

  assign sum     = {bus.in_data[DATA_BITS-1], bus.in_data} + {bus.bias[DATA_BITS-1], bus.bias};
  assign sum_sat = sum[DATA_BITS] ^ sum[DATA_BITS-1];
  assign sum_q   = !sum_sat ? sum[DATA_BITS-1:0] : (sum[DATA_BITS] ? MIN_NEG : MAX_POS);

  always_comb begin
    act_data = s1_data;
    case (s1_mode)
      2'b01: if (s1_data[DATA_BITS-1]) act_data = '0;
`ifdef LEAKY_RELU_EN
      2'b10: if (s1_data[DATA_BITS-1]) act_data = $signed(s1_data) >>> 3;
`else
      2'b10: if (s1_data[DATA_BITS-1]) act_data = '0;
`endif
      default: act_data = s1_data;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= 2'b00;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (enable) begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= sum_q;
        s1_mode <= bus.act_mode;
      end
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= act_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s2_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sat_count <= 8'd0;
    else if (accept && sum_sat && sat_count != 8'hFF)
      sat_count <= sat_count + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (flush) state_next = DRAIN;
             else if (accept) state_next = RUN;
      RUN:   if (flush) state_next = DRAIN;
      DRAIN: if (all_empty) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = !reset && enable && (state == IDLE || state == RUN)
                   && (occupancy < (CW+1)'(FIFO_DEPTH));
    done = (state == DONE);
    busy = (state != IDLE) || !all_empty;
  end
endmodule

// File: doc/q115_act_stage.md
Q115_ACT_STAGE -- requirements
Module: q115_act_stage

Interface
REQ-001 SHALL have parameter DATA_BITS, default 16, Q1.15 word width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, low freezes pipeline stages and blocks acceptance.
REQ-006 SHALL have port in_valid / in_ready, input / output, 1 each, FMA accumulator result handshake.
REQ-007 SHALL have port in_data, input, DATA_BITS, Q1.15 accumulated sum from the FMA unit.
REQ-008 SHALL have port bias, input, DATA_BITS, Q1.15 bias, sampled with in_data.
REQ-009 SHALL have port act_mode, input, 2, 00 bypass, 01 ReLU, 10 leaky ReLU, 11 reserved (acts as bypass); sampled with in_data.
REQ-010 SHALL have port flush, input, 1, single-cycle drain request.
REQ-011 SHALL have port out_valid / out_ready, output / input, 1 each, result handshake.
REQ-012 SHALL have port out_data, output, DATA_BITS, Q1.15 activated result (FIFO head).
REQ-013 SHALL have ports busy (1), done (1), sat_count (8), all outputs: activity, drain-complete pulse, saturation counter.

Function
REQ-014 SHALL accept a beat on a rising edge where in_valid && in_ready; in_data, bias and act_mode travel together.
REQ-015 SHALL drive in_ready = enable && state in {IDLE,RUN} && (fifo_count + occupied stages) < FIFO_DEPTH, so the pipeline never stalls.
REQ-016 Stage 1 (register loaded at accept edge k) SHALL hold the 17-bit signed sum in_data+bias, saturated to 0x7FFF / 0x8000 on overflow.
REQ-017 Stage 2 (loaded at edge k+1) SHALL apply act_mode: bypass passes; ReLU maps negatives to 0x0000; leaky maps negative x to x>>>3 (arithmetic).
REQ-018 The FIFO SHALL be written at edge k+2; out_valid SHALL be high after edge k+2 when the FIFO was previously empty (latency 3 clocks).
REQ-019 The FIFO SHALL be first-word-fall-through; pop on out_valid && out_ready; order preserved; pops permitted while enable is low.
REQ-020 Simultaneous push and pop SHALL keep fifo_count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-021 sat_count SHALL increment on each stage-1 saturation and hold at 255.
REQ-022 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-023 IDLE->RUN on an accepted beat; IDLE or RUN ->DRAIN on flush (beat accepted in the same cycle is included in the drain).
REQ-024 DRAIN SHALL force in_ready low; DRAIN->DONE when both stages and FIFO are empty.
REQ-025 DONE SHALL assert done for exactly one cycle, then go to IDLE; flush in DONE or DRAIN is ignored.
REQ-026 busy SHALL be high when state != IDLE or any stage or FIFO entry is occupied.

Reset
REQ-027 On reset assertion (asynchronously, mid-operation included): state IDLE, stages and FIFO emptied, pointers 0, out_valid 0, out_data 0x0000, in_ready 0 while reset high, busy 0, done 0, sat_count 0.
REQ-028 Beats in flight at reset SHALL be discarded and never emitted.

Configuration
REQ-029 Macro LEAKY_RELU_EN SHALL compile in the leaky path; defined: act_mode 10 behaves per REQ-017.
REQ-030 Without LEAKY_RELU_EN, act_mode 10 SHALL behave exactly as ReLU and no shifter logic is instantiated.

Verification
REQ-031 ReLU, bias 0: in 0x1234 -> out 0x1234, out_valid 3 clocks after accept; in 0x8123 -> 0x0000.
REQ-032 Bypass: in 0x7000 + bias 0x2000 -> 0x7FFF; in 0x9000 + bias 0xA000 -> 0x8000; sat_count = 2.
REQ-033 Mode 10, in 0xFF00, bias 0: with LEAKY_RELU_EN -> 0xFFE0; without -> 0x0000.
REQ-034 out_ready=0, offer 6 beats: exactly 4 accepted, in_ready low after; release out_ready -> 4 results in order, then in_ready returns high.
REQ-035 Accept 2 beats, flush with 2nd accept: in_ready low, both emitted, done pulses 1 cycle after FIFO and stages empty, state IDLE next.
REQ-036 Reset asserted between clock edges with 3 FIFO entries: out_valid, busy fall immediately; no stale data after release.
